// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the per-approach sensor combiners, the phase sequencer and the lamp
// drivers.
//   phase_req      : one traffic request per phase (bit i = any sensor of phase i)
//   preempt        : level-sensitive emergency preempt
//   preempt_phase  : phase to force green while preempt is high (>= NPHASE is ignored)
//   phase_light    : lamp colour per phase, 2 bits each, encoded 0=red 1=yellow 2=green
//                    (same order as the colors type the lamp drivers use)
//   cur_phase      : phase currently green/yellow, or last served phase during all-red
//   preempt_active : high while the green phase is held by preempt
// The master modport is the requester/observer side; the slave modport is the sequencer.
interface traffic_phase_sequencer_if #(
  parameter int unsigned NPHASE = 5,
  parameter int unsigned PW     = $clog2(NPHASE)
);
  logic [NPHASE-1:0]      phase_req;
  logic                   preempt;
  logic [PW-1:0]          preempt_phase;
  logic [NPHASE-1:0][1:0] phase_light;
  logic [PW-1:0]          cur_phase;
  logic                   preempt_active;

  modport master (
    output phase_req, preempt, preempt_phase,
    input  phase_light, cur_phase, preempt_active
  );

  modport slave (
    input  phase_req, preempt, preempt_phase,
    output phase_light, cur_phase, preempt_active
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Sequences NPHASE mutually exclusive signal phases through GREEN -> YELLOW -> ALLRED with
// round-robin service and emergency preempt.
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus_io : traffic_phase_sequencer_if.slave (requests/preempt in, lamps/status out)
// Outputs are Moore: decoded from the registered state, current phase and preempt flag.
module traffic_phase_sequencer #(
  parameter int unsigned NPHASE     = 5,
  parameter int unsigned VACANT_CYC = 4,
  parameter int unsigned MAX_GREEN  = 9,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned PW         = $clog2(NPHASE)
) (
  input  logic                       clk,
  input  logic                       reset,
  traffic_phase_sequencer_if.slave   bus_io
);

  localparam int unsigned Max01  = (VACANT_CYC > MAX_GREEN) ? VACANT_CYC : MAX_GREEN;
  localparam int unsigned Max23  = (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
  localparam int unsigned MaxCyc = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned CW     = $clog2(MaxCyc + 1);

  localparam logic [CW-1:0] VacLast  = CW'(VACANT_CYC - 1);
  localparam logic [CW-1:0] WaitLast = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YelLast  = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] ArLast   = CW'(ALLRED_CYC - 1);

  localparam logic [1:0] LampRed    = 2'd0;
  localparam logic [1:0] LampYellow = 2'd1;
  localparam logic [1:0] LampGreen  = 2'd2;

  typedef enum logic [1:0] {StGreen, StYellow, StAllRed} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [CW-1:0] vac_q, vac_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          pre_q, pre_d;

  logic          pp_vld;
  logic          own_req;
  logic          other_req;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  int unsigned   scan_idx;
  logic [PW-1:0] scan_pw;

  assign pp_vld    = bus_io.preempt && (32'(bus_io.preempt_phase) < NPHASE);
  assign own_req   = bus_io.phase_req[cur_q];
  assign other_req = (bus_io.phase_req & ~(NPHASE'(1) << cur_q)) != '0;

  // Round-robin scan starting after the last served phase and ending with it.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = cur_q;
    scan_idx  = 0;
    scan_pw   = '0;
    for (int unsigned k = 1; k <= NPHASE; k++) begin
      scan_idx = (32'(cur_q) + k) % NPHASE;
      scan_pw  = PW'(scan_idx);
      if (!grant_vld && bus_io.phase_req[scan_pw]) begin
        grant_vld = 1'b1;
        grant_idx = scan_pw;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    vac_d   = vac_q;
    wait_d  = wait_q;
    tmr_d   = tmr_q;
    pre_d   = pre_q;
    case (state_q)
      StGreen: begin
        if (pp_vld && (bus_io.preempt_phase != cur_q)) begin
          state_d = StYellow;
          tmr_d   = '0;
          pre_d   = 1'b0;
        end else if (pp_vld) begin
          // Held by preempt: counters frozen, exit conditions ignored.
          pre_d = 1'b1;
        end else if (pre_q) begin
          // Preempt just released: this cycle only clears, timing restarts next cycle.
          pre_d  = 1'b0;
          vac_d  = '0;
          wait_d = '0;
        end else if ((!own_req && vac_q == VacLast) || (other_req && wait_q == WaitLast)) begin
          state_d = StYellow;
          tmr_d   = '0;
        end else begin
          vac_d  = own_req ? '0 : ((vac_q != '1) ? vac_q + 1'b1 : vac_q);
          wait_d = other_req ? ((wait_q != '1) ? wait_q + 1'b1 : wait_q) : '0;
        end
      end
      StYellow: begin
        if (tmr_q == YelLast) begin
          state_d = StAllRed;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StAllRed: begin
        if (tmr_q != ArLast) begin
          tmr_d = tmr_q + 1'b1;
        end else if (pp_vld || grant_vld) begin
          state_d = StGreen;
          cur_d   = pp_vld ? bus_io.preempt_phase : grant_idx;
          pre_d   = pp_vld;
          vac_d   = '0;
          wait_d  = '0;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = StAllRed;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StAllRed;
      cur_q   <= PW'(NPHASE - 1);
      vac_q   <= '0;
      wait_q  <= '0;
      tmr_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      vac_q   <= vac_d;
      wait_q  <= wait_d;
      tmr_q   <= tmr_d;
      pre_q   <= pre_d;
    end
  end

  logic [NPHASE-1:0][1:0] lights;

  always_comb begin
    lights = {NPHASE{LampRed}};
    case (state_q)
      StGreen:  lights[cur_q] = LampGreen;
      StYellow: lights[cur_q] = LampYellow;
      default:  lights = {NPHASE{LampRed}};
    endcase
  end

  assign bus_io.phase_light    = lights;
  assign bus_io.cur_phase      = cur_q;
  assign bus_io.preempt_active = pre_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: directed scenarios with literal expectations followed by
// randomized requests/preempts, all checked every cycle against a rule-level model.
module tb_traffic_phase_sequencer;

  localparam int N  = 5;
  localparam int VC = 4;
  localparam int MG = 9;
  localparam int YC = 2;
  localparam int AC = 1;

  localparam int ModeGreen  = 0;
  localparam int ModeYellow = 1;
  localparam int ModeAllRed = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  traffic_phase_sequencer_if #(.NPHASE(N)) ifc ();

  traffic_phase_sequencer #(
    .NPHASE    (N),
    .VACANT_CYC(VC),
    .MAX_GREEN (MG),
    .YELLOW_CYC(YC),
    .ALLRED_CYC(AC)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus_io(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- rule-level model ----------------
  int m_mode, m_cur, m_vac, m_wait, m_t, m_held;

  task automatic model_step();
    logic [N-1:0] req;
    bit pv, own, oth, found;
    int pp, p;
    req = ifc.phase_req;
    pp  = int'(ifc.preempt_phase);
    pv  = ifc.preempt && (pp < N);
    case (m_mode)
      ModeGreen: begin
        own = req[m_cur];
        oth = (req & ~(N'(1) << m_cur)) != 0;
        if (pv && pp != m_cur) begin
          m_mode = ModeYellow; m_t = 0; m_held = 0;
        end else if (pv) begin
          m_held = 1;
        end else if (m_held != 0) begin
          m_held = 0; m_vac = 0; m_wait = 0;
        end else if ((!own && m_vac == VC - 1) || (oth && m_wait == MG - 1)) begin
          m_mode = ModeYellow; m_t = 0;
        end else begin
          m_vac  = own ? 0 : m_vac + 1;
          m_wait = oth ? m_wait + 1 : 0;
        end
      end
      ModeYellow: begin
        m_t++;
        if (m_t == YC) begin m_mode = ModeAllRed; m_t = 0; end
      end
      default: begin
        m_t++;
        if (m_t >= AC) begin
          found = 0;
          if (pv) begin
            found = 1; m_cur = pp; m_held = 1;
          end else begin
            for (int k = 1; k <= N; k++) begin
              p = (m_cur + k) % N;
              if (!found && req[p]) begin found = 1; m_cur = p; m_held = 0; end
            end
          end
          if (found) begin m_mode = ModeGreen; m_vac = 0; m_wait = 0; m_t = 0; end
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = ModeAllRed; m_cur = N - 1; m_vac = 0; m_wait = 0; m_t = 0; m_held = 0;
      end else begin
        model_step();
      end
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int exp_light;
    exp_light = 0;
    if (m_mode == ModeGreen)  exp_light = 2 << (2 * m_cur);
    if (m_mode == ModeYellow) exp_light = 1 << (2 * m_cur);
    chk("model_light", int'(ifc.phase_light), exp_light);
    chk("model_cur", int'(ifc.cur_phase), m_cur);
    chk("model_pactive", int'(ifc.preempt_active), m_held);
  end

  // Cycles until the lamp pattern changes, called and returning at posedge+1.
  task automatic measure(input int budget, output int n);
    logic [2*N-1:0] start;
    start = ifc.phase_light;
    n = 0;
    while (ifc.phase_light == start && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int n;

  initial begin
    ifc.phase_req     = '0;
    ifc.preempt       = 1'b0;
    ifc.preempt_phase = '0;
    repeat (3) step();

    // Reset state
    chk("rst_light", int'(ifc.phase_light), 0);
    chk("rst_cur", int'(ifc.cur_phase), N - 1);
    chk("rst_pactive", int'(ifc.preempt_active), 0);

    // 1: single request, one all-red cycle then phase 2 green
    rst = 1'b0;
    ifc.phase_req = 5'b00100;
    step();
    chk("t1_light", int'(ifc.phase_light), 32);
    chk("t1_cur", int'(ifc.cur_phase), 2);

    // 2: vacancy exit with nobody else waiting, then indefinite all-red
    ifc.phase_req = '0;
    measure(50, n); chk("t2_green_len", n, 4);
    chk("t2_yellow", int'(ifc.phase_light), 16);
    measure(50, n); chk("t2_yellow_len", n, 2);
    measure(30, n); chk("t2_allred_hold", n, 30);
    chk("t2_cur", int'(ifc.cur_phase), 2);

    // 3: max-green exit of phase 0 with phase 3 waiting
    ifc.phase_req = 5'b00001;
    step();
    chk("t3_green0", int'(ifc.phase_light), 2);
    ifc.phase_req = 5'b01001;
    measure(50, n); chk("t3_green_len", n, 9);
    chk("t3_yellow0", int'(ifc.phase_light), 1);
    measure(50, n); chk("t3_yellow_len", n, 2);
    measure(50, n); chk("t3_allred_len", n, 1);
    chk("t3_green3", int'(ifc.phase_light), 128);

    // 4: round-robin wrap from 3 -> 0, then from 1 -> 2
    ifc.phase_req = 5'b00101;
    measure(50, n); chk("t4_vac_len", n, 4);
    measure(50, n);
    measure(50, n);
    chk("t4_wrap_grant", int'(ifc.cur_phase), 0);
    chk("t4_wrap_light", int'(ifc.phase_light), 2);
    ifc.phase_req = 5'b00010;
    measure(50, n); measure(50, n); measure(50, n);
    chk("t4_serve1", int'(ifc.cur_phase), 1);
    ifc.phase_req = 5'b00101;
    measure(50, n); measure(50, n); measure(50, n);
    chk("t4_rr_grant", int'(ifc.cur_phase), 2);
    chk("t4_rr_light", int'(ifc.phase_light), 32);

    // 5: get phase 1 green, then preempt to phase 4
    ifc.phase_req = 5'b00010;
    n = 0;
    while (ifc.phase_light != 10'd8 && n < 60) begin step(); n++; end
    chk("t5_green1", int'(ifc.phase_light), 8);
    ifc.preempt = 1'b1;
    ifc.preempt_phase = 3'd4;
    ifc.phase_req = 5'b11111;
    step();
    chk("t5_yellow1", int'(ifc.phase_light), 4);
    measure(50, n); chk("t5_yellow_len", n, 2);
    measure(50, n); chk("t5_allred_len", n, 1);
    chk("t5_green4", int'(ifc.phase_light), 512);
    chk("t5_pactive", int'(ifc.preempt_active), 1);
    measure(25, n); chk("t5_hold", n, 25);
    chk("t5_pactive_hold", int'(ifc.preempt_active), 1);
    ifc.preempt = 1'b0;
    step();  // release cycle only clears the counters
    chk("t5_pactive_drop", int'(ifc.preempt_active), 0);
    measure(50, n); chk("t5_yield_len", n, 9);
    chk("t5_yellow4", int'(ifc.phase_light), 256);

    // 6: asynchronous reset mid-yellow, no edge needed
    #2 rst = 1'b1;
    #1;
    chk("t6_light", int'(ifc.phase_light), 0);
    chk("t6_cur", int'(ifc.cur_phase), 4);
    chk("t6_pactive", int'(ifc.preempt_active), 0);
    step();
    rst = 1'b0;

    // Randomized traffic with occasional (sometimes invalid) preempts
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) ifc.phase_req = N'($urandom) & N'($urandom);
      if (!ifc.preempt) begin
        if ($urandom_range(0, 39) == 0) begin
          ifc.preempt = 1'b1;
          ifc.preempt_phase = 3'($urandom_range(0, 7));
        end
      end else begin
        if ($urandom_range(0, 14) == 0) ifc.preempt = 1'b0;
        else if ($urandom_range(0, 29) == 0) ifc.preempt_phase = 3'($urandom_range(0, 7));
      end
      step();
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Parametrised successor to the fixed 5-direction, 20-state traffic light controller.
- Sequences NPHASE mutually exclusive signal phases through GREEN -> YELLOW -> ALLRED.
- Timing is configurable.
- Round-robin service starts from the phase after the last one served.
- An emergency preempt input forces a chosen phase green.
- Sits between the per-approach sensor combiners, which produce one request per phase, and the lamp drivers, which use the colors type from light_package.

Parameters:
NPHASE, 5, number of phases; one phase green at a time; legal range 2..16
VACANT_CYC, 4, consecutive cycles with own request low that end a green
MAX_GREEN, 9, consecutive cycles with another request pending that end a green
YELLOW_CYC, 2, yellow duration in cycles; minimum 1
ALLRED_CYC, 1, minimum all-red duration in cycles; minimum 1
PW, $clog2(NPHASE), phase index width (derived)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
phase_req  input  NPHASE  per-phase traffic request; bit i = any sensor of phase i
preempt  input  1  level-sensitive emergency preempt
preempt_phase  input  PW  phase to force green while preempt=1; values >= NPHASE are ignored
phase_light  output  NPHASE x colors  lamp colour per phase (red/yellow/green)
cur_phase  output  PW  phase currently green or yellow; last served phase while in ALLRED
preempt_active  output  1  high while the green phase is held by preempt

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high. All state is registered.
- Reset values: state=ALLRED, all phase_light=red, cur_phase=NPHASE-1 (so phase 0 has first priority), all counters 0, preempt_active=0.
- Reset asserted mid-operation goes immediately to the reset values; a yellow is not completed.
- States are GREEN, YELLOW and ALLRED. The outputs are Moore.
  - GREEN: phase_light[cur_phase]=green, all others red.
  - YELLOW: phase_light[cur_phase]=yellow, all others red.
  - ALLRED: all phases red.
- GREEN counters:
  - vac_ctr increments on each cycle phase_req[cur_phase]=0; it clears to 0 when the request is high.
  - wait_ctr increments on each cycle any other phase_req bit is 1; it clears to 0 when none are.
  - Both saturate and clear on entry to GREEN.
- GREEN exit to YELLOW on the next edge when either condition holds:
  - vac_ctr==VACANT_CYC-1 and own request is low in the current cycle, or
  - wait_ctr==MAX_GREEN-1 and another request is high in the current cycle.
  With the defaults, the green ends after the 4th consecutive vacant cycle or the 9th waiting cycle.
  A vacancy exit happens even if no other phase is requesting.
- YELLOW lasts exactly YELLOW_CYC cycles, then goes to ALLRED.
- ALLRED lasts at least ALLRED_CYC cycles. On its last cycle, and on every later cycle, arbitration runs:
  - If preempt=1 and preempt_phase<NPHASE: grant preempt_phase.
  - Else, if any request is pending: grant the first set bit scanning cur_phase+1, cur_phase+2, ..., wrapping mod NPHASE and ending with cur_phase itself.
  - Else: stay in ALLRED, all red, and keep cur_phase.
  - A grant loads cur_phase and enters GREEN on the next edge.
- Preempt:
  - preempt=1 during GREEN of a phase other than preempt_phase: go to YELLOW on the next edge. The normal yellow and all-red timing still applies.
  - preempt=1 during GREEN of preempt_phase: hold GREEN, freeze the counters, and set preempt_active=1.
  - preempt deasserting while held: clear the counters and resume normal GREEN timing next cycle; preempt_active=0.
  - preempt during YELLOW or ALLRED does not shorten either state.
  - preempt_phase changing while held is treated as a new preempt to a different phase.
- Simultaneous events: if the vacancy and max-green conditions are both true, there is a single YELLOW transition. A preempt to the current phase overrides both exit conditions.
- Counter widths are $clog2(max(VACANT_CYC, MAX_GREEN, YELLOW_CYC, ALLRED_CYC)+1).

Test Plan:
1. Reset, then phase_req=00100 (NPHASE=5) -> ALLRED for 1 cycle, then phase 2 green; cur_phase=2; all other phases red.
2. Phase 2 green; drop req2 and hold all requests 0 -> green for exactly 4 more cycles, yellow for 2, then all red; the block stays in ALLRED indefinitely.
3. Phase 0 green with req0 held 1 and req3=1 -> phase 0 yellow after 9 green cycles, then all red for 1 cycle, then phase 3 green.
4. Round-robin: last served=3, phase_req=00101 at the all-red decision -> phase 0 granted via wrap, not phase 2. With the same requests and last served=1 -> phase 2 granted.
5. Phase 1 green, preempt=1 with preempt_phase=4 -> phase 1 yellow next cycle, 2 yellow, 1 all-red, then phase 4 green with preempt_active=1. Phase 4 then holds green for 20+ cycles with all other requests high; after preempt drops, it yields after 9 cycles.
6. Assert reset asynchronously mid-yellow -> all red immediately, with no clock edge required; cur_phase=4.
